// File: rtl/pd_bb_vote_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pd_bb_pkg
// Brief    : Shared types, widths and helpers for the bang-bang vote filter.
// Revision : 1.0
// ============================================================================
package pd_bb_pkg;

    typedef logic signed [1:0] vote_t;

    localparam vote_t c_vote_dn   = -2'sd1;
    localparam vote_t c_vote_zero =  2'sd0;
    localparam vote_t c_vote_up   =  2'sd1;

    localparam int STAT_W = 16;

    // Width of the signed per-word vote sum.
    function automatic int net_w(input int n);
        return $clog2(n) + 2;
    endfunction

    function automatic logic [STAT_W-1:0] stat_sat_add(input logic [STAT_W-1:0] a,
                                                       input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pd_bb_vote_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : pd_bb_vote_filter_if
// Brief    : Sample/correction bundle of the vote filter (PD_BB_STATS_EN adds stats).
// Revision : 1.0
// ============================================================================
interface pd_bb_vote_filter_if
    import pd_bb_pkg::*;
#(
    parameter int N_LANE = 4,
    parameter int ACC_W  = 8
);
    logic              VALID;
    logic [N_LANE-1:0] D_DATA;
    logic [N_LANE-1:0] D_EDGE;
    logic [ACC_W-2:0]  THRESH;
    logic              BYPASS;
    logic [N_LANE-1:0] D_RETIME;
    logic              UPb;
    logic              DOWN;
`ifdef PD_BB_STATS_EN
    logic              STAT_CLR;
    logic [STAT_W-1:0] TRANS_CNT;
    logic [STAT_W-1:0] EARLY_CNT;

    modport master (output VALID, D_DATA, D_EDGE, THRESH, BYPASS, STAT_CLR,
                    input  D_RETIME, UPb, DOWN, TRANS_CNT, EARLY_CNT);
    modport slave  (input  VALID, D_DATA, D_EDGE, THRESH, BYPASS, STAT_CLR,
                    output D_RETIME, UPb, DOWN, TRANS_CNT, EARLY_CNT);
`else
    modport master (output VALID, D_DATA, D_EDGE, THRESH, BYPASS,
                    input  D_RETIME, UPb, DOWN);
    modport slave  (input  VALID, D_DATA, D_EDGE, THRESH, BYPASS,
                    output D_RETIME, UPb, DOWN);
`endif
endinterface
`default_nettype wire

// File: rtl/pd_bb_vote_filter_lane_vote.sv
`default_nettype none
// ============================================================================
// Module   : pd_bb_lane_vote
// Brief    : Alexander early/late vote for one data/edge/data sample triple.
// Revision : 1.0
// ============================================================================
module pd_bb_lane_vote
    import pd_bb_pkg::*;
(
    input  wire logic i_d_prev,
    input  wire logic i_d_cur,
    input  wire logic i_d_edge,
    output vote_t     o_vote,
    output logic      o_trans
);

    always_comb begin
        o_trans = i_d_prev ^ i_d_cur;
        o_vote  = c_vote_zero;
        // Edge agreeing with the older bit means the sampling clock is early.
        if (o_trans) begin
            o_vote = (i_d_edge == i_d_prev) ? c_vote_dn : c_vote_up;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pd_bb_vote_filter.sv
`default_nettype none
// ============================================================================
// Module   : pd_bb_vote_filter
// Brief    : Multi-lane bang-bang phase detector with integrating vote filter.
//            Optional transition/early counters when PD_BB_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module pd_bb_vote_filter
    import pd_bb_pkg::*;
#(
    parameter int N_LANE = 4,
    parameter int ACC_W  = 8
)(
    input  wire logic CLK,
    input  wire logic RSTb,
    inout  wire       VDD,
    inout  wire       VSS,
    pd_bb_vote_filter_if.slave bus
);

    localparam int NET_W = net_w(N_LANE);
    localparam logic signed [ACC_W:0] c_acc_max = (ACC_W+1)'(2**(ACC_W-1) - 1);
    localparam logic signed [ACC_W:0] c_acc_min = -c_acc_max - 1;

    logic                     r_s1_vld;
    logic [N_LANE-1:0]        r_data;
    logic [N_LANE-1:0]        r_edge;
    logic                     r_s1_prev;
    logic                     r_s1_prev_vld;
    logic                     r_dprev;
    logic                     r_prev_vld;
    logic                     r_s2_vld;
    logic signed [NET_W-1:0]  r_net;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_upb;
    logic                     r_down;

    vote_t                    w_vote [N_LANE];
    logic [N_LANE-1:0]        w_trans;
    logic signed [NET_W-1:0]  w_net_sum;
    logic [ACC_W-2:0]         w_thr_eff;
    logic signed [ACC_W:0]    w_thr;
    logic signed [ACC_W:0]    w_thr_neg;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_sat;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     w_upb_nxt;
    logic                     w_down_nxt;

    // Stage 1: capture the word; lane 0 sees the MSB of the previous valid word.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_s1_vld      <= 1'b0;
            r_data        <= '0;
            r_edge        <= '0;
            r_s1_prev     <= 1'b0;
            r_s1_prev_vld <= 1'b0;
            r_dprev       <= 1'b0;
            r_prev_vld    <= 1'b0;
        end else begin
            r_s1_vld <= bus.VALID;
            if (bus.VALID) begin
                r_data        <= bus.D_DATA;
                r_edge        <= bus.D_EDGE;
                r_s1_prev     <= r_dprev;
                r_s1_prev_vld <= r_prev_vld;
                r_dprev       <= bus.D_DATA[N_LANE-1];
                r_prev_vld    <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
        logic  w_prev_bit;
        logic  w_lane_en;
        vote_t w_raw;
        logic  w_raw_trans;

        if (gi == 0) begin : g_first
            assign w_prev_bit = r_s1_prev;
            assign w_lane_en  = r_s1_prev_vld;
        end else begin : g_rest
            assign w_prev_bit = r_data[gi-1];
            assign w_lane_en  = 1'b1;
        end

        pd_bb_lane_vote u_vote (
            .i_d_prev (w_prev_bit),
            .i_d_cur  (r_data[gi]),
            .i_d_edge (r_edge[gi]),
            .o_vote   (w_raw),
            .o_trans  (w_raw_trans)
        );

        assign w_vote[gi]  = w_lane_en ? w_raw : c_vote_zero;
        assign w_trans[gi] = w_lane_en & w_raw_trans;
    end

    always_comb begin
        w_net_sum = '0;
        for (int i = 0; i < N_LANE; i++) begin
            w_net_sum = w_net_sum + NET_W'(w_vote[i]);
        end
    end

    // Stage 2: registered net vote.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_s2_vld <= 1'b0;
            r_net    <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_net <= w_net_sum;
            end
        end
    end

    // Stage 3: integrate with one guard bit, saturate, then compare to the trip level.
    always_comb begin
        w_thr_eff  = (bus.THRESH == '0) ? (ACC_W-1)'(1) : bus.THRESH;
        w_thr      = {2'b00, w_thr_eff};
        w_thr_neg  = -w_thr;
        w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_net);
        if (w_sum > c_acc_max) begin
            w_sat = c_acc_max;
        end else if (w_sum < c_acc_min) begin
            w_sat = c_acc_min;
        end else begin
            w_sat = w_sum;
        end

        w_upb_nxt  = 1'b1;
        w_down_nxt = 1'b0;
        w_acc_nxt  = r_acc;
        if (bus.BYPASS) begin
            w_acc_nxt = '0;
            if (r_s2_vld) begin
                w_upb_nxt  = ~(~r_net[NET_W-1] & (|r_net));
                w_down_nxt = r_net[NET_W-1];
            end
        end else if (r_s2_vld) begin
            if (w_sat >= w_thr) begin
                w_upb_nxt = 1'b0;
                w_acc_nxt = '0;
            end else if (w_sat <= w_thr_neg) begin
                w_down_nxt = 1'b1;
                w_acc_nxt  = '0;
            end else begin
                w_acc_nxt = w_sat[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_acc  <= '0;
            r_upb  <= 1'b1;
            r_down <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_upb  <= w_upb_nxt;
            r_down <= w_down_nxt;
        end
    end

    assign bus.D_RETIME = r_data;
    assign bus.UPb      = r_upb;
    assign bus.DOWN     = r_down;

`ifdef PD_BB_STATS_EN
    logic [STAT_W-1:0] r_trans_cnt;
    logic [STAT_W-1:0] r_early_cnt;
    logic [STAT_W-1:0] w_trans_inc;
    logic [STAT_W-1:0] w_early_inc;

    always_comb begin
        w_trans_inc = '0;
        w_early_inc = '0;
        for (int i = 0; i < N_LANE; i++) begin
            w_trans_inc = w_trans_inc + STAT_W'(w_trans[i]);
            w_early_inc = w_early_inc + STAT_W'(w_vote[i] == c_vote_dn);
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_trans_cnt <= '0;
            r_early_cnt <= '0;
        end else if (bus.STAT_CLR) begin
            r_trans_cnt <= '0;
            r_early_cnt <= '0;
        end else if (r_s1_vld) begin
            r_trans_cnt <= stat_sat_add(r_trans_cnt, w_trans_inc);
            r_early_cnt <= stat_sat_add(r_early_cnt, w_early_inc);
        end
    end

    assign bus.TRANS_CNT = r_trans_cnt;
    assign bus.EARLY_CNT = r_early_cnt;
`else
    wire w_unused_trans = ^w_trans;
`endif

    // Supply pins carry no logic function.
    wire w_unused_supply = VDD ^ VSS;

endmodule
`default_nettype wire

// File: tb/tb_pd_bb_vote_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pd_bb_vote_filter
// Brief    : Scoreboard bench for pd_bb_vote_filter (N_LANE=4, ACC_W=8).
// Revision : 1.0
// ============================================================================
module tb_pd_bb_vote_filter;
    import pd_bb_pkg::*;

    localparam int N_LANE = 4;
    localparam int ACC_W  = 8;

    logic CLK  = 1'b0;
    logic RSTb = 1'b0;
    wire  VDD;
    wire  VSS;
    assign VDD = 1'b1;
    assign VSS = 1'b0;

    pd_bb_vote_filter_if #(.N_LANE(N_LANE), .ACC_W(ACC_W)) bus ();

    pd_bb_vote_filter #(.N_LANE(N_LANE), .ACC_W(ACC_W)) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .VDD  (VDD),
        .VSS  (VSS),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic                    upb;
        logic                    down;
        logic signed [ACC_W-1:0] acc;
    } exp_t;

    exp_t              q[$];
    int                checks = 0;
    int                errors = 0;
    logic              m_prev = 1'b0;
    logic              m_prev_vld = 1'b0;
    int                m_acc = 0;
    logic [N_LANE-1:0] m_retime = '0;

    task automatic check_eq(input string tag, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model_net(input logic prev, input logic pvld,
                                     input logic [N_LANE-1:0] d, input logic [N_LANE-1:0] e);
        int   n;
        logic dp;
        n = 0;
        for (int i = 0; i < N_LANE; i++) begin
            if (i == 0) dp = prev;
            else        dp = d[i-1];
            if (!(i == 0 && !pvld) && dp != d[i]) begin
                n += (e[i] == dp) ? -1 : 1;
            end
        end
        return n;
    endfunction

    // One clock of stimulus; output due from the word two steps back is checked.
    task automatic step(input logic v, input logic [N_LANE-1:0] d, input logic [N_LANE-1:0] e);
        exp_t x;
        int   net, s, thr;
        @(negedge CLK);
        bus.VALID  = v;
        bus.D_DATA = d;
        bus.D_EDGE = e;
        x.upb  = 1'b1;
        x.down = 1'b0;
        if (v) begin
            net        = model_net(m_prev, m_prev_vld, d, e);
            m_prev     = d[N_LANE-1];
            m_prev_vld = 1'b1;
            m_retime   = d;
            thr        = (bus.THRESH == 0) ? 1 : int'(bus.THRESH);
            if (bus.BYPASS) begin
                x.upb  = !(net > 0);
                x.down = (net < 0);
                m_acc  = 0;
            end else begin
                s = m_acc + net;
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                if (s >= thr) begin
                    x.upb = 1'b0;
                    m_acc = 0;
                end else if (s <= -thr) begin
                    x.down = 1'b1;
                    m_acc  = 0;
                end else begin
                    m_acc = s;
                end
            end
        end else if (bus.BYPASS) begin
            m_acc = 0;
        end
        x.acc = ACC_W'(m_acc);
        q.push_back(x);
        @(posedge CLK);
        #1;
        check_eq("d_retime", bus.D_RETIME, m_retime);
        if (q.size() >= 3) begin
            x = q.pop_front();
            check_eq("upb",  bus.UPb,   x.upb);
            check_eq("down", bus.DOWN,  x.down);
            check_eq("acc",  dut.r_acc, x.acc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    initial begin
        bus.VALID  = 1'b0;
        bus.D_DATA = '0;
        bus.D_EDGE = '0;
        bus.THRESH = 7'd4;
        bus.BYPASS = 1'b0;
`ifdef PD_BB_STATS_EN
        bus.STAT_CLR = 1'b0;
`endif
        #12;
        check_eq("rst_upb",    bus.UPb, 1);
        check_eq("rst_down",   bus.DOWN, 0);
        check_eq("rst_retime", bus.D_RETIME, 0);
        check_eq("rst_acc",    dut.r_acc, 0);
        @(negedge CLK);
        RSTb = 1'b1;

        // All-late word after a priming word with MSB 1.
        bus.THRESH = 7'd4;
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1010, 4'b1010);
        idle(3);

        // +3 per word: accumulate 3, 6, then trip at 9.
        bus.THRESH = 7'd8;
        step(1'b1, 4'b0100, 4'b0100);
        step(1'b1, 4'b1011, 4'b1001);
        step(1'b1, 4'b0100, 4'b0100);
        idle(3);

        // Constant zero data: no transitions, no pulses.
        bus.THRESH = 7'd2;
        for (int i = 0; i < 100; i++) step(1'b1, 4'b0000, 4'($urandom_range(0, 15)));
        idle(2);

        // Bypass: two early, one late.
        bus.BYPASS = 1'b1;
        step(1'b1, 4'b1010, 4'b1100);
        idle(3);
        bus.BYPASS = 1'b0;

        // Valid gap holds the accumulator.
        bus.THRESH = 7'd4;
        step(1'b1, 4'b1110, 4'b0010);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b1110, 4'b0010);
        idle(3);

        // All-early word trips DOWN.
        step(1'b1, 4'b1010, 4'b0101);
        idle(3);

        // Zero threshold behaves as one.
        bus.THRESH = 7'd0;
        step(1'b1, 4'b1110, 4'b0010);
        idle(3);

        // Ramp to the top of the accumulator range.
        bus.THRESH = 7'd127;
        for (int i = 0; i < 32; i++) step(1'b1, 4'b1010, 4'b1010);
        idle(3);

        for (int seg = 0; seg < 3; seg++) begin
            bus.THRESH = 7'($urandom_range(0, 12));
            for (int i = 0; i < 120; i++) begin
                step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            end
            idle(3);
        end

        // Reset asserted while an UP pulse is on the output.
        bus.THRESH = 7'd4;
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1010, 4'b1010);
        idle(2);
        #1;
        RSTb = 1'b0;
        #1;
        check_eq("midrst_upb",    bus.UPb, 1);
        check_eq("midrst_down",   bus.DOWN, 0);
        check_eq("midrst_retime", bus.D_RETIME, 0);
        check_eq("midrst_acc",    dut.r_acc, 0);
        q.delete();
        m_prev     = 1'b0;
        m_prev_vld = 1'b0;
        m_acc      = 0;
        m_retime   = '0;
        bus.THRESH = 7'd2;
        @(negedge CLK);
        RSTb = 1'b1;
        // Lane 0 must stay silent on the first word, so NET is +1, below threshold.
        step(1'b1, 4'b1110, 4'b0010);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
